// File: rtl/code_checker_pkg.sv
// code_checker_pkg: shared types, constants and scoring helpers for the code checker
package code_checker_pkg;
  localparam int DIGITS = 4;
  typedef logic [3:0] digit_t;
  localparam digit_t MAX_DIGIT = 4'd9;
  typedef digit_t [DIGITS-1:0] code_t;
  typedef enum logic [1:0] {IDLE, ENTRY, SCORE, DONE} state_t;
  // Secret digits above MAX_DIGIT can never be matched by a valid guess digit.
  function automatic logic [2:0] exact_count(input code_t s, input code_t g);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < DIGITS; i++) n += 3'(s[i] == g[i] && s[i] <= MAX_DIGIT);
    return n;
  endfunction
  function automatic logic [2:0] common_count(input code_t s, input code_t g);
    logic [2:0] n, cs, cg;
    n = '0;
    for (int v = 0; v <= int'(MAX_DIGIT); v++) begin
      cs = '0;
      cg = '0;
      for (int i = 0; i < DIGITS; i++) begin
        cs += 3'(s[i] == 4'(v));
        cg += 3'(g[i] == 4'(v));
      end
      n += (cs < cg) ? cs : cg;
    end
    return n;
  endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector that stays blind until its history flop has seen the input once after reset
module edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic rise
);
  logic prev, armed;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= d;
      armed <= 1'b1;
    end
  end
  assign rise = d & ~prev & armed;
endmodule

// File: rtl/code_checker.sv
// code_checker: four-digit code guessing game with exact/partial scoring
module code_checker
  import code_checker_pkg::*;
#(
  parameter int MAX_GUESSES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] RN_1,
  input  logic [3:0] RN_2,
  input  logic [3:0] RN_3,
  input  logic [3:0] RN_4,
  input  logic       LOAD,
  input  logic [3:0] DIGIT,
  input  logic       ENTER,
  output logic [2:0] EXACT,
  output logic [2:0] PARTIAL,
  output logic       RESULT_VALID,
  output logic       WIN,
  output logic       LOSE,
  output logic [3:0] GUESS_CNT,
  output logic [1:0] POS,
  output logic       DIG_ERR
);
  logic load_edge, enter_edge, digit_ok, win_nx, lose_nx;
  logic [2:0] exact_c, common_c;
  logic [3:0] cnt_inc;
  state_t state, state_nx;
  code_t secret, guess;
  edge_detect u_load (.CLK(CLK), .RST(RST), .d(LOAD), .rise(load_edge));
  edge_detect u_enter (.CLK(CLK), .RST(RST), .d(ENTER), .rise(enter_edge));
  assign exact_c = exact_count(secret, guess);
  assign common_c = common_count(secret, guess);
  assign digit_ok = DIGIT <= MAX_DIGIT;
  assign cnt_inc = (GUESS_CNT == 4'hF) ? GUESS_CNT : GUESS_CNT + 4'd1;
  assign win_nx = exact_c == 3'd4;
  assign lose_nx = !win_nx && cnt_inc == 4'(MAX_GUESSES);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= state_nx;
  end
  // LOAD wins over everything, including a simultaneous ENTER edge.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = load_edge ? ENTRY : state;
      ENTRY: state_nx = (!load_edge && enter_edge && digit_ok && POS == 2'd3) ? SCORE : ENTRY;
      SCORE: state_nx = load_edge ? ENTRY : (win_nx || lose_nx) ? DONE : ENTRY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      secret <= '0;
      guess <= '0;
      POS <= '0;
      GUESS_CNT <= '0;
      EXACT <= '0;
      PARTIAL <= '0;
      RESULT_VALID <= 1'b0;
      WIN <= 1'b0;
      LOSE <= 1'b0;
      DIG_ERR <= 1'b0;
    end else begin
      RESULT_VALID <= 1'b0;
      DIG_ERR <= 1'b0;
      if (load_edge) begin
        secret <= {RN_4, RN_3, RN_2, RN_1};
        POS <= '0;
        GUESS_CNT <= '0;
        EXACT <= '0;
        PARTIAL <= '0;
        WIN <= 1'b0;
        LOSE <= 1'b0;
      end else if (state == ENTRY && enter_edge) begin
        if (digit_ok) begin
          guess[POS] <= DIGIT;
          POS <= POS + 2'd1;
        end else DIG_ERR <= 1'b1;
      end else if (state == SCORE) begin
        EXACT <= exact_c;
        PARTIAL <= common_c - exact_c;
        RESULT_VALID <= 1'b1;
        GUESS_CNT <= cnt_inc;
        WIN <= win_nx;
        LOSE <= lose_nx;
      end
    end
  end
endmodule
